video_scandoubler: RTL and testbench

- Downstream stage of the video timing/palette block.
- Consumes its 256x240 pixel stream: one dot per 4 I_clock, 341 dots x 262 lines.
- Emits a line-doubled 256x480 stream at 2 I_clock per dot for a 31 kHz display.
- Uses two ping-pong line buffers: one row is written while the previous row is read out twice.

---
 rtl/video_scandoubler.sv | 147 ++++++++++++++
 tb/tb_video_scandoubler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_scandoubler.sv
// Line doubler: stores each 256-pixel source row in one of two ping-pong buffers
// and replays the previous row twice at double dot rate for a 31 kHz display.
module video_scandoubler #(
  parameter int H_DOTS       = 341,
  parameter int V_OUT_LINES  = 524,
  parameter int ACTIVE_W     = 256,
  parameter int ACTIVE_H_OUT = 480,
  parameter int HSYNC_START  = 275,
  parameter int HSYNC_END    = 300,
  parameter int VSYNC_LINE   = 484
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_vid_rise,
  input  logic       I_vid_de,
  input  logic       I_vid_hsync,
  input  logic       I_vid_vsync,
  input  logic [7:0] I_vid_red,
  input  logic [7:0] I_vid_green,
  input  logic [7:0] I_vid_blue,
  output logic       O_dbl_rise,
  output logic       O_dbl_de,
  output logic       O_dbl_hsync,
  output logic       O_dbl_vsync,
  output logic [7:0] O_dbl_red,
  output logic [7:0] O_dbl_green,
  output logic [7:0] O_dbl_blue
);

  logic        r_hsPrev;
  logic        r_vsPrev;
  logic        r_wrSel;
  logic [8:0]  r_wrX;
  logic [1:0]  r_valid;
  logic        r_phase;
  logic [8:0]  r_outX;
  logic [9:0]  r_outY;
  logic        r_vsPending;
  logic [23:0] r_mem [0:2*ACTIVE_W-1];

  logic        w_hsFall;
  logic        w_vsFall;
  logic        w_wrEn;
  logic        w_wrap;
  logic [7:0]  w_rdX;
  logic [8:0]  w_rdAddr;
  logic        w_deNext;

  // Source syncs only change meaningfully on dot strobes, so edges are judged there.
  assign w_hsFall = I_vid_rise & r_hsPrev & ~I_vid_hsync;
  assign w_vsFall = I_vid_rise & r_vsPrev & ~I_vid_vsync;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_hsPrev <= 1'b1;
      r_vsPrev <= 1'b1;
    end else if (I_vid_rise) begin
      r_hsPrev <= I_vid_hsync;
      r_vsPrev <= I_vid_vsync;
    end
  end

  assign w_wrEn = I_vid_rise & I_vid_de & (r_wrX < 9'(ACTIVE_W)) & ~w_hsFall;

  always_ff @(posedge I_clock) begin
    if (w_wrEn) begin
      r_mem[{r_wrSel, r_wrX[7:0]}] <= {I_vid_red, I_vid_green, I_vid_blue};
    end
  end

  // Clearing the incoming buffer's valid flag keeps stale rows off screen.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_wrSel <= 1'b0;
      r_wrX   <= 9'd0;
      r_valid <= 2'b00;
    end else if (w_hsFall) begin
      r_wrSel           <= ~r_wrSel;
      r_wrX             <= 9'd0;
      r_valid[~r_wrSel] <= 1'b0;
    end else if (w_wrEn) begin
      r_wrX            <= r_wrX + 9'd1;
      r_valid[r_wrSel] <= 1'b1;
    end
  end

  assign w_wrap     = r_phase & (r_outX == 9'(H_DOTS - 1));
  assign O_dbl_rise = r_phase;

  // A source hsync fall re-locks the output dot counter; out_y still steps on a coincident wrap.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_phase     <= 1'b0;
      r_outX      <= 9'd0;
      r_outY      <= 10'd0;
      r_vsPending <= 1'b0;
    end else begin
      if (w_hsFall) begin
        r_phase <= 1'b0;
        r_outX  <= 9'(HSYNC_START);
      end else begin
        r_phase <= ~r_phase;
        if (r_phase) begin
          r_outX <= w_wrap ? 9'd0 : r_outX + 9'd1;
        end
      end
      if (w_wrap) begin
        if (r_vsPending | w_vsFall) begin
          r_outY <= 10'(VSYNC_LINE);
        end else if (r_outY == 10'(V_OUT_LINES - 1)) begin
          r_outY <= 10'd0;
        end else begin
          r_outY <= r_outY + 10'd1;
        end
        r_vsPending <= 1'b0;
      end else if (w_vsFall) begin
        r_vsPending <= 1'b1;
      end
    end
  end

  assign w_rdX    = r_outX[7:0] - 8'd1;
  assign w_rdAddr = {~r_wrSel, w_rdX};
  assign w_deNext = (r_outX >= 9'd1) && (r_outX <= 9'(ACTIVE_W)) &&
                    (r_outY < 10'(ACTIVE_H_OUT)) && r_valid[~r_wrSel];

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      O_dbl_hsync <= 1'b1;
      O_dbl_vsync <= 1'b1;
      O_dbl_de    <= 1'b0;
      O_dbl_red   <= 8'd0;
      O_dbl_green <= 8'd0;
      O_dbl_blue  <= 8'd0;
    end else begin
      O_dbl_hsync <= !((r_outX >= 9'(HSYNC_START)) && (r_outX <= 9'(HSYNC_END)));
      O_dbl_vsync <= !((r_outY >= 10'(VSYNC_LINE)) && (r_outY <= 10'(VSYNC_LINE + 5)));
      O_dbl_de    <= w_deNext;
      if (w_deNext) begin
        {O_dbl_red, O_dbl_green, O_dbl_blue} <= r_mem[w_rdAddr];
      end else begin
        {O_dbl_red, O_dbl_green, O_dbl_blue} <= 24'd0;
      end
    end
  end

endmodule

// File: tb/tb_video_scandoubler.sv
// Self-checking bench for video_scandoubler: source line generator, arithmetic
// reference model of the doubled output, and table-driven line/reset scenarios.
module tb_video_scandoubler;

  logic       I_clock = 1'b0;
  logic       I_reset = 1'b0;
  logic       I_vid_rise = 1'b0;
  logic       I_vid_de = 1'b0;
  logic       I_vid_hsync = 1'b1;
  logic       I_vid_vsync = 1'b1;
  logic [7:0] I_vid_red = 8'd0;
  logic [7:0] I_vid_green = 8'd0;
  logic [7:0] I_vid_blue = 8'd0;
  logic       O_dbl_rise;
  logic       O_dbl_de;
  logic       O_dbl_hsync;
  logic       O_dbl_vsync;
  logic [7:0] O_dbl_red;
  logic [7:0] O_dbl_green;
  logic [7:0] O_dbl_blue;

  video_scandoubler dut (
    .I_clock(I_clock), .I_reset(I_reset),
    .I_vid_rise(I_vid_rise), .I_vid_de(I_vid_de),
    .I_vid_hsync(I_vid_hsync), .I_vid_vsync(I_vid_vsync),
    .I_vid_red(I_vid_red), .I_vid_green(I_vid_green), .I_vid_blue(I_vid_blue),
    .O_dbl_rise(O_dbl_rise), .O_dbl_de(O_dbl_de),
    .O_dbl_hsync(O_dbl_hsync), .O_dbl_vsync(O_dbl_vsync),
    .O_dbl_red(O_dbl_red), .O_dbl_green(O_dbl_green), .O_dbl_blue(O_dbl_blue)
  );

  always #5 I_clock = ~I_clock;

  typedef struct {
    logic        rise, de, hs, vs;
    logic [23:0] rgb;
    logic [27:0] expOut;
  } ResetVec_t;

  // kind: 0 ramp pixels, 1 random 256 dots, 2 de held low, 3 random 300 dots
  typedef struct {
    int kind;
    int nDots;
    int vsDot;
    int expDe;
  } LineVec_t;

  ResetVec_t rstTab [6];
  LineVec_t  lineTab [14];

  int nVectors = 0;
  int nMiscompares = 0;
  int deCount = 0;
  int vsLowCount = 0;

  // Reference model state: output position is derived from clocks since the last re-lock.
  int          mBase, mK, mY;
  bit          mPend, mHsPrev, mVsPrev, curValid, dispValid;
  logic [23:0] curRow [$];
  logic [23:0] dispRow [0:255];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nVectors++;
    if (act !== expv) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic modelReset();
    mBase = 0; mK = 0; mY = 0; mPend = 0;
    mHsPrev = 1; mVsPrev = 1;
    curValid = 0; dispValid = 0;
    curRow.delete();
  endtask

  // One clock: predict the registered outputs, advance the model, then compare.
  task automatic tick();
    int          x;
    bit          ph, hsFall, vsFall, wrap, eDe, eHs, eVs;
    logic [23:0] eRgb;
    @(posedge I_clock);
    x   = (mBase + mK / 2) % 341;
    ph  = (mK % 2) == 1;
    eDe = (x >= 1) && (x <= 256) && (mY < 480) && dispValid;
    eHs = !((x >= 275) && (x <= 300));
    eVs = !((mY >= 484) && (mY <= 489));
    eRgb = eDe ? dispRow[x - 1] : 24'd0;
    hsFall = I_vid_rise && mHsPrev && !I_vid_hsync;
    vsFall = I_vid_rise && mVsPrev && !I_vid_vsync;
    wrap   = ph && (x == 340);
    if (hsFall) begin
      foreach (curRow[i]) dispRow[i] = curRow[i];
      dispValid = curValid;
      curRow.delete();
      curValid = 0;
    end else if (I_vid_rise && I_vid_de && curRow.size() < 256) begin
      curRow.push_back({I_vid_red, I_vid_green, I_vid_blue});
      curValid = 1;
    end
    if (I_vid_rise) begin
      mHsPrev = I_vid_hsync;
      mVsPrev = I_vid_vsync;
    end
    if (wrap) begin
      mY = (mPend || vsFall) ? 484 : ((mY == 523) ? 0 : mY + 1);
      mPend = 0;
    end else if (vsFall) begin
      mPend = 1;
    end
    if (hsFall) begin
      mBase = 275;
      mK = 0;
    end else begin
      mK++;
    end
    #1;
    checkOutput("dot", {4'd0, O_dbl_rise, O_dbl_de, O_dbl_hsync, O_dbl_vsync,
                        O_dbl_red, O_dbl_green, O_dbl_blue},
                {4'd0, (mK % 2) == 1, eDe, eHs, eVs, eRgb});
    if (O_dbl_de) deCount++;
    if (!O_dbl_vsync) vsLowCount++;
  endtask

  // Four clocks per source dot; non-strobe clocks carry junk to prove strobe gating.
  task automatic applyStimulus(input int kind, input int nDots, input int vsDot, input int stopDot);
    int         nDe;
    logic [7:0] n;
    nDe = (kind == 3) ? 300 : 256;
    for (int d = 0; d < nDots && d < stopDot; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          I_vid_rise  = 1'b1;
          I_vid_hsync = !(d <= 25);
          I_vid_vsync = !(vsDot >= 0 && d >= vsDot);
          I_vid_de    = (kind != 2) && (d >= 40) && (d < 40 + nDe);
          n = 8'(d - 40);
          if (kind == 0) {I_vid_red, I_vid_green, I_vid_blue} = {n, ~n, 8'h5A};
          else {I_vid_red, I_vid_green, I_vid_blue} = 24'($urandom);
        end else begin
          I_vid_rise  = 1'b0;
          I_vid_hsync = 1'($urandom);
          I_vid_vsync = 1'($urandom);
          I_vid_de    = 1'($urandom);
          {I_vid_red, I_vid_green, I_vid_blue} = 24'($urandom);
        end
        tick();
      end
    end
  endtask

  task automatic runLine(input int idx);
    deCount = 0;
    applyStimulus(lineTab[idx].kind, lineTab[idx].nDots, lineTab[idx].vsDot, 1000);
    checkOutput($sformatf("deClocks[%0d]", idx), 32'(deCount), 32'(lineTab[idx].expDe));
  endtask

  task automatic applyResetTable();
    for (int i = 0; i < 6; i++) begin
      {I_vid_rise, I_vid_de, I_vid_hsync, I_vid_vsync} =
        {rstTab[i].rise, rstTab[i].de, rstTab[i].hs, rstTab[i].vs};
      {I_vid_red, I_vid_green, I_vid_blue} = rstTab[i].rgb;
      @(posedge I_clock);
      #1;
      checkOutput($sformatf("reset[%0d]", i),
                  {4'd0, O_dbl_rise, O_dbl_de, O_dbl_hsync, O_dbl_vsync,
                   O_dbl_red, O_dbl_green, O_dbl_blue},
                  {4'd0, rstTab[i].expOut});
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      rstTab[i].rise = 1'($urandom);
      rstTab[i].de   = 1'($urandom);
      rstTab[i].hs   = 1'($urandom);
      rstTab[i].vs   = 1'($urandom);
      rstTab[i].rgb  = 24'($urandom);
      rstTab[i].expOut = {1'b0, 1'b0, 1'b1, 1'b1, 24'd0};
    end
    // Expected de-high clocks during each source line (shows the previous row twice).
    lineTab[0]  = '{0, 341, -1, 0};
    lineTab[1]  = '{1, 341, -1, 1024};
    lineTab[2]  = '{2, 341, -1, 1024};
    lineTab[3]  = '{1, 341, -1, 0};
    lineTab[4]  = '{3, 341, -1, 1024};
    lineTab[5]  = '{2, 33,  -1, 0};
    lineTab[6]  = '{0, 341, -1, 0};
    lineTab[7]  = '{1, 341, -1, 1024};
    lineTab[8]  = '{0, 341, 33, 0};
    lineTab[9]  = '{1, 341, -1, 0};
    lineTab[10] = '{1, 341, -1, 0};
    lineTab[11] = '{1, 341, -1, 0};
    lineTab[12] = '{0, 341, -1, 0};
    lineTab[13] = '{1, 341, -1, 1024};

    applyResetTable();
    #2;
    I_reset = 1'b1;
    modelReset();

    // Line 5 is 33 dots so line 6's hsync fall lands on an output wrap;
    // line 8's vsync fall at dot 33 also lands on a wrap.
    for (int i = 0; i < 8; i++) runLine(i);
    vsLowCount = 0;
    for (int i = 8; i < 12; i++) runLine(i);
    checkOutput("vsyncLowClocks", 32'(vsLowCount), 32'(6 * 682));

    // Reset in the middle of a row that is being written.
    applyStimulus(0, 341, -1, 150);
    #2;
    I_reset = 1'b0;
    #1;
    checkOutput("asyncReset", {4'd0, O_dbl_rise, O_dbl_de, O_dbl_hsync, O_dbl_vsync,
                               O_dbl_red, O_dbl_green, O_dbl_blue},
                {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'd0});
    applyResetTable();
    #2;
    I_reset = 1'b1;
    modelReset();
    runLine(12);
    runLine(13);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
